// File: rtl/d_phy_clk_div_if.sv
// Configuration/status bundle for d_phy_clk_div: per-channel ratios and sync in,
// divided clocks, period strobes and sticky error flags out.
interface d_phy_clk_div_if #(
    parameter int unsigned NUM_CH = 2,
    parameter int unsigned CNT_W  = 8
);
    logic [NUM_CH*CNT_W-1:0] ratio_i;
    logic                    sync_i;
    logic [NUM_CH-1:0]       clk_o;
    logic [NUM_CH-1:0]       period_stb_o;
    logic [NUM_CH-1:0]       cfg_err_o;

    modport master (
        output ratio_i,
        output sync_i,
        input  clk_o,
        input  period_stb_o,
        input  cfg_err_o
    );

    modport slave (
        input  ratio_i,
        input  sync_i,
        output clk_o,
        output period_stb_o,
        output cfg_err_o
    );
endinterface

// File: rtl/d_phy_clk_div.sv
// Multi-channel runtime-programmable clock divider with boundary-safe ratio updates.
// Optional macro D_PHY_CLK_DIV_STB_EN enables the per-channel period start strobe.
module d_phy_clk_div #(
    parameter int unsigned NUM_CH = 2,
    parameter int unsigned CNT_W  = 8
) (
    input logic             hs_clk,
    input logic             rst,
    d_phy_clk_div_if.slave  bus
);

    typedef enum logic [1:0] {
        StIdle,
        StLow,
        StHigh
    } state_e;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        state_e           r_state, w_state_d;
        logic [CNT_W-1:0] r_cnt, w_cnt_d;
        logic [CNT_W-1:0] r_hi, w_hi_d;
        logic             r_clk, w_clk_d;
        logic             r_err, w_err_d;
        logic             w_start;
        logic [CNT_W-1:0] w_req;
        logic [CNT_W-1:0] w_eff;
        logic [CNT_W-1:0] w_lo;

        assign w_req = bus.ratio_i[k*CNT_W +: CNT_W];
        // Ratio 1 cannot make a clock; clamp to the shortest legal period.
        assign w_eff = (w_req == CNT_W'(1)) ? CNT_W'(2) : w_req;
        assign w_lo  = w_eff - (w_eff >> 1);

        always_comb begin
            w_state_d = r_state;
            w_cnt_d   = r_cnt;
            w_hi_d    = r_hi;
            w_clk_d   = r_clk;
            w_err_d   = r_err;
            w_start   = 1'b0;

            unique case (r_state)
                StIdle: begin
                    if (w_req != '0) w_start = 1'b1;
                end
                StLow: begin
                    if (r_cnt == '0) begin
                        w_state_d = StHigh;
                        w_cnt_d   = r_hi - CNT_W'(1);
                        w_clk_d   = 1'b1;
                    end else begin
                        w_cnt_d = r_cnt - CNT_W'(1);
                    end
                end
                StHigh: begin
                    if (r_cnt == '0) begin
                        if (w_req != '0) begin
                            w_start = 1'b1;
                        end else begin
                            w_state_d = StIdle;
                            w_clk_d   = 1'b0;
                        end
                    end else begin
                        w_cnt_d = r_cnt - CNT_W'(1);
                    end
                end
                default: begin
                    w_state_d = StIdle;
                    w_clk_d   = 1'b0;
                end
            endcase

            // A sync on a natural boundary collapses into the same single restart.
            if (bus.sync_i && (w_req != '0)) w_start = 1'b1;

            if (w_start) begin
                w_state_d = StLow;
                w_cnt_d   = w_lo - CNT_W'(1);
                w_hi_d    = w_eff >> 1;
                w_clk_d   = 1'b0;
                if (w_req == CNT_W'(1)) w_err_d = 1'b1;
            end
        end

        always_ff @(posedge hs_clk or posedge rst) begin
            if (rst) begin
                r_state <= StIdle;
                r_cnt   <= '0;
                r_hi    <= '0;
                r_clk   <= 1'b0;
                r_err   <= 1'b0;
            end else begin
                r_state <= w_state_d;
                r_cnt   <= w_cnt_d;
                r_hi    <= w_hi_d;
                r_clk   <= w_clk_d;
                r_err   <= w_err_d;
            end
        end

        assign bus.clk_o[k]     = r_clk;
        assign bus.cfg_err_o[k] = r_err;

`ifdef D_PHY_CLK_DIV_STB_EN
        logic r_stb;

        always_ff @(posedge hs_clk or posedge rst) begin
            if (rst) begin
                r_stb <= 1'b0;
            end else begin
                r_stb <= w_start;
            end
        end

        assign bus.period_stb_o[k] = r_stb;
`else
        assign bus.period_stb_o[k] = 1'b0;
`endif
    end

endmodule
